apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_cmd_master_pkg.sv | 15 +
 rtl/apb_wait_timer.sv | 26 ++
 rtl/apb_cmd_master.sv | 109 ++++++++++
 tb/tb_apb_cmd_master.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_cmd_master_pkg.sv
// rtl/apb_cmd_master_pkg.sv - shared state encoding and default sizing for the APB command master
package apb_cmd_master_pkg;

   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - counts ACCESS cycles spent waiting on pready
module apb_wait_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [7:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + 8'd1;
   end

   // High during the last wait cycle allowed, so the LIMIT-th stalled cycle ends the transfer
   assign expired = (count == 8'(LIMIT - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - single-outstanding command to APB initiator bridge with wait-state timeout
module apb_cmd_master
   import apb_cmd_master_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   state_t state;
   logic   timer_clear;
   logic   timer_enable;
   logic   wait_expired;

   assign timer_clear  = (state != ST_ACCESS);
   assign timer_enable = (state == ST_ACCESS) && !pready;

   apb_wait_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (wait_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cmd_ready   <= 1'b0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  paddr     <= cmd_addr;
                  pwrite    <= cmd_write;
                  pwdata    <= cmd_wdata;
                  psel      <= 1'b1;
                  state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable <= 1'b1;
               state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // pready wins over a timeout landing on the same cycle
               if (pready) begin
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= pwrite ? '0 : prdata;
                  rsp_err     <= pslverr;
                  rsp_timeout <= 1'b0;
                  state       <= ST_RESP;
               end else if (wait_expired) begin
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  state       <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - scoreboard bench for apb_cmd_master with an APB slave model
module tb_apb_cmd_master;

   localparam int TO = 16;

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      int          w;
      logic        err;
      logic [31:0] rdata;
   } plan_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        to;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [7:0]  paddr;
   logic        psel, penable, pwrite;
   logic [31:0] pwdata, prdata;
   logic        pready, pslverr;

   int    vectors = 0;
   int    miscompares = 0;
   plan_t plan_q[$];
   exp_t  exp_q[$];
   bit    rand_done;

   apb_cmd_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // APB slave: w stalled ACCESS cycles, then pready with the planned data; garbage elsewhere
   plan_t cur;
   int    k = 0;
   bit    in_acc = 0;
   always @(negedge clk) begin
      if (rst) begin
         in_acc  = 0;
         pready  = 1'b0;
         prdata  = '0;
         pslverr = 1'b0;
      end else begin
         if (psel && !penable) begin
            check("setup_plan_avail", 64'(plan_q.size() != 0), 64'(1));
            if (plan_q.size() != 0) begin
               cur = plan_q.pop_front();
               check("setup_paddr", 64'(paddr), 64'(cur.addr));
               check("setup_pwrite", 64'(pwrite), 64'(cur.wr));
               check("setup_pwdata", 64'(pwdata), 64'(cur.wdata));
            end
            k = 0;
         end
         if (psel && penable) begin
            k++;
            in_acc = 1;
            if (k == cur.w + 1) begin
               pready  = 1'b1;
               prdata  = cur.rdata;
               pslverr = cur.err;
            end else begin
               pready  = 1'b0;
               prdata  = $urandom;
               pslverr = 1'($urandom_range(0, 1));
            end
         end else begin
            if (in_acc) begin
               check("access_len", 64'(k), 64'((cur.w >= TO) ? TO : cur.w + 1));
               in_acc = 0;
            end
            pready  = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            pslverr = 1'($urandom_range(0, 1));
         end
      end
   end

   // Response monitor: pops the scoreboard on each handshake and checks stalls hold steady
   bit          stalled = 0;
   logic [31:0] h_rdata;
   logic        h_err, h_to;
   exp_t        e;
   always @(negedge clk) begin
      #1;
      if (rsp_valid && !rst) begin
         check("rsp_psel_low", 64'(psel), 64'(0));
         if (stalled) begin
            check("stall_rdata", 64'(rsp_rdata), 64'(h_rdata));
            check("stall_err", 64'(rsp_err), 64'(h_err));
            check("stall_timeout", 64'(rsp_timeout), 64'(h_to));
         end
         if (rsp_ready) begin
            stalled = 0;
            check("rsp_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
               check("rsp_err", 64'(rsp_err), 64'(e.err));
               check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
            end
         end else begin
            stalled = 1;
            h_rdata = rsp_rdata;
            h_err   = rsp_err;
            h_to    = rsp_timeout;
         end
      end else begin
         stalled = 0;
      end
   end

   task automatic send(input logic wr, input logic [7:0] a, input logic [31:0] d, input int w,
                       input logic er, input logic [31:0] rd, input bit expect_rsp);
      plan_t p;
      exp_t  x;
      int    n;
      p.wr = wr; p.addr = a; p.wdata = d; p.w = w; p.err = er; p.rdata = rd;
      plan_q.push_back(p);
      if (expect_rsp) begin
         if (w >= TO) begin
            x.rdata = '0; x.err = 1'b1; x.to = 1'b1;
         end else begin
            x.rdata = wr ? 32'h0 : rd; x.err = er; x.to = 1'b0;
         end
         exp_q.push_back(x);
      end
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("cmd_handshake", 64'(cmd_ready), 64'(1));
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_addr  = 8'($urandom);
      cmd_wdata = $urandom;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("drain_exp_q", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      check("rst_psel", 64'(psel), 64'(0));
      check("rst_penable", 64'(penable), 64'(0));
      check("rst_pwrite", 64'(pwrite), 64'(0));
      check("rst_paddr", 64'(paddr), 64'(0));
      check("rst_pwdata", 64'(pwdata), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
      check("rst_rsp_err", 64'(rsp_err), 64'(0));
      check("rst_rsp_timeout", 64'(rsp_timeout), 64'(0));
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

      // zero-wait write, cycle-exact latency
      send(1'b1, 8'h0C, 32'hDEADBEEF, 0, 1'b0, 32'h0, 1'b1);
      check("t1_psel", 64'(psel), 64'(1));
      check("t1_penable", 64'(penable), 64'(0));
      check("t1_pwdata", 64'(pwdata), 64'hDEADBEEF);
      @(negedge clk);
      check("t2_psel", 64'(psel), 64'(1));
      check("t2_penable", 64'(penable), 64'(1));
      @(negedge clk);
      check("t3_rsp_valid", 64'(rsp_valid), 64'(1));
      check("t3_psel", 64'(psel), 64'(0));
      check("t3_cmd_ready", 64'(cmd_ready), 64'(0));
      @(negedge clk);
      check("t4_cmd_ready", 64'(cmd_ready), 64'(1));
      drain();

      send(1'b0, 8'h00, 32'h0, 3, 1'b0, 32'h0000005A, 1'b1);
      send(1'b1, 8'h04, 32'h11223344, 0, 1'b1, 32'h0, 1'b1);
      drain();

      // response backpressure
      rsp_ready = 1'b0;
      send(1'b0, 8'h10, 32'h0, 1, 1'b0, 32'h12345678, 1'b1);
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_rsp_valid_seen", 64'(rsp_valid), 64'(1));
      repeat (5) begin
         @(negedge clk);
         check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
         check("bp_cmd_ready", 64'(cmd_ready), 64'(0));
         check("bp_psel", 64'(psel), 64'(0));
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_cmd_ready_after", 64'(cmd_ready), 64'(1));
      drain();

      // reset in the middle of ACCESS: no response may appear
      send(1'b0, 8'h20, 32'h0, 30, 1'b0, 32'hCAFEF00D, 1'b0);
      @(negedge clk);
      check("mid_access_penable", 64'(penable), 64'(1));
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_psel", 64'(psel), 64'(0));
      check("mid_rst_penable", 64'(penable), 64'(0));
      check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
      repeat (2) begin
         @(negedge clk);
         check("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
      end

      // timeout boundary: never ready, and ready exactly on the last allowed cycle
      send(1'b0, 8'h30, 32'h0, TO, 1'b0, 32'hA5A5A5A5, 1'b1);
      send(1'b0, 8'h34, 32'h0, TO - 1, 1'b0, 32'h5A5A5A5A, 1'b1);
      drain();

      rand_done = 0;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               int r;
               int w;
               r = $urandom_range(0, 9);
               w = (r < 7) ? $urandom_range(0, 3) : $urandom_range(TO - 2, TO + 3);
               send(1'($urandom_range(0, 1)), 8'($urandom), $urandom, w,
                    1'($urandom_range(0, 3) == 0), $urandom, 1'b1);
            end
            drain();
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(negedge clk);
               rsp_ready = ($urandom_range(0, 3) != 0);
            end
            rsp_ready = 1'b1;
         end
      join

      check("plan_q_empty", 64'(plan_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
